prbs_checker: RTL and testbench

- Receive-side companion to the team's Fibonacci LFSR generator. It synchronises to a serial pseudo-random stream produced by the same polynomial, then checks every subsequent bit against its own prediction.
- Reports lock status, per-bit error pulses and a saturating error count.
- Sits at the far end of a test/secure-scan data path, e.g. TDO capture, to verify PRBS integrity.

---
 rtl/prbs_checker.sv | 100 ++++++++++
 tb/tb_prbs_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: locks onto a Fibonacci-LFSR PRBS stream and counts mispredicted bits once locked.
module prbs_checker #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h10000001,
    parameter int                    LOCK_GOOD  = 16,
    parameter int                    LOSS_ERRS  = 8,
    parameter int                    CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);
    localparam int FW = $clog2(LFSR_WIDTH + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t                st;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [FW-1:0]         fill_cnt;
    logic [7:0]            good_cnt;
    logic [7:0]            bad_cnt;
    logic                  pred;
    logic                  mis;
    logic                  err;
    logic [LFSR_WIDTH-1:0] shifted;

    assign pred    = ^(lfsr & LFSR_POLY);
    assign mis     = din ^ pred;
    assign err     = din_valid && st == LOCKED && mis;
    assign shifted = {lfsr[LFSR_WIDTH-2:0], din};
    assign state   = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= HUNT;
            lfsr      <= '0;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err;
            if (err_clr)
                err_count <= CNT_W'(err);
            else if (err && err_count != '1)
                err_count <= err_count + CNT_W'(1);
            if (din_valid) begin
                case (st)
                    HUNT: begin
                        lfsr <= shifted;
                        if (fill_cnt == FW'(LFSR_WIDTH - 1)) begin
                            fill_cnt <= '0;
                            if (|shifted) begin
                                st       <= VERIFY;
                                good_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                    VERIFY: begin
                        lfsr <= shifted;
                        if (mis) begin
                            st       <= HUNT;
                            fill_cnt <= '0;
                        end else if (good_cnt == 8'(LOCK_GOOD - 1)) begin
                            st      <= LOCKED;
                            locked  <= 1'b1;
                            bad_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so one corrupted bit costs exactly one error
                        lfsr <= {lfsr[LFSR_WIDTH-2:0], pred};
                        if (!mis)
                            bad_cnt <= '0;
                        else if (bad_cnt == 8'(LOSS_ERRS - 1)) begin
                            st       <= HUNT;
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 8'd1;
                        end
                    end
                    default: st <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: drives generator streams with injected faults and compares against a bit-history model.
module tb_prbs_checker;
    localparam int          W    = 32;
    localparam logic [31:0] POLY = 32'h10000001;
    localparam int          LG   = 16;
    localparam int          LE   = 8;

    logic        clk = 0;
    logic        reset = 1;
    logic        din = 0;
    logic        din_valid = 0;
    logic        err_clr = 0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
    logic [1:0]  state, state4;

    int checks = 0;
    int errors = 0;

    logic [31:0] g;
    bit          hist[$];
    int          m_state, fill, good, bad, m_cnt, m_cnt4;
    bit          m_pulse;

    prbs_checker dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .err_clr(err_clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .state(state4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pred();
        bit p = 0;
        for (int k = 0; k < W; k++)
            if (POLY[k] && k < hist.size()) p ^= hist[k];
        return p;
    endfunction

    task automatic push(input bit b);
        hist.push_front(b);
        if (hist.size() > W) void'(hist.pop_back());
    endtask

    task automatic model_reset();
        hist.delete();
        m_state = 0; fill = 0; good = 0; bad = 0; m_cnt = 0; m_cnt4 = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit clr);
        bit p, e, nz;
        e = 0;
        if (v) begin
            p = model_pred();
            if (m_state == 0) begin
                push(d);
                fill++;
                if (fill == W) begin
                    fill = 0;
                    nz = 0;
                    foreach (hist[k]) nz |= hist[k];
                    if (nz) begin m_state = 1; good = 0; end
                end
            end else if (m_state == 1) begin
                push(d);
                if (d != p) begin m_state = 0; fill = 0; end
                else begin
                    good++;
                    if (good == LG) begin m_state = 2; bad = 0; end
                end
            end else begin
                push(p);
                if (d != p) begin
                    e = 1;
                    bad++;
                    if (bad == LE) begin m_state = 0; fill = 0; end
                end else bad = 0;
            end
        end
        m_pulse = e;
        m_cnt  = clr ? int'(e) : (e && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt4 = clr ? int'(e) : (e && m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
    endtask

    task automatic check_all();
        check("state", state, m_state);
        check("locked", locked, int'(m_state == 2));
        check("err_pulse", err_pulse, m_pulse);
        check("err_count", err_count, m_cnt);
        check("err_count4", err_count4, m_cnt4);
    endtask

    task automatic gen(output bit b);
        b = ^(g & POLY);
        g = {g[30:0], b};
    endtask

    task automatic send(input bit d, input bit v, input bit clr);
        din = d; din_valid = v; err_clr = clr;
        @(posedge clk);
        model_step(d, v, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic [31:0] seed);
        reset = 1; din_valid = 0; err_clr = 0;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        reset = 0;
        g = seed;
    endtask

    task automatic run_bits(input int n, input bit inv);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            send(b ^ inv, 1, 0);
        end
    endtask

    initial begin
        bit b;
        int nv, burst;
        // Clean stream: VERIFY after bit 32, lock after bit 48
        do_reset(32'hFF);
        for (int i = 1; i <= 1000; i++) begin
            gen(b);
            send(b, 1, 0);
            if (i == 31) check("hunt_at_31", state, 0);
            if (i == 32) check("verify_at_32", state, 1);
            if (i == 47) check("unlocked_at_47", locked, 0);
            if (i == 48) check("locked_at_48", locked, 1);
        end
        check("clean_count", err_count, 0);
        // Single inverted bit while locked
        do_reset(32'hFF);
        for (int i = 1; i <= 1000; i++) begin
            gen(b);
            send(b ^ (i == 200), 1, 0);
            if (i == 200) check("pulse_200", err_pulse, 1);
            if (i == 201) check("pulse_201", err_pulse, 0);
        end
        check("single_count", err_count, 1);
        check("single_locked", locked, 1);
        // Eight consecutive errors drop lock, then relock
        do_reset(32'hFF);
        for (int i = 1; i <= 400; i++) begin
            gen(b);
            send(b ^ (i >= 300 && i <= 307), 1, 0);
            if (i == 306) check("still_locked_306", locked, 1);
            if (i == 307) check("lost_at_307", locked, 0);
            if (i == 307) check("burst_count", err_count, 8);
            if (i == 354) check("unlocked_354", locked, 0);
            if (i == 355) check("relock_355", locked, 1);
        end
        // All-zero input never leaves HUNT
        do_reset(32'hFF);
        for (int i = 0; i < 1000; i++) send(0, 1, 0);
        check("zero_state", state, 0);
        check("zero_count", err_count, 0);
        // Error during VERIFY restarts the hunt
        do_reset(32'hFF);
        for (int i = 1; i <= 120; i++) begin
            gen(b);
            send(b ^ (i == 40), 1, 0);
            if (i == 40) check("verify_err_hunt", state, 0);
            if (i == 87) check("unlocked_87", locked, 0);
            if (i == 88) check("relock_88", locked, 1);
        end
        check("verify_err_count", err_count, 0);
        // Alternating din_valid
        do_reset(32'hFF);
        nv = 0;
        for (int c = 0; c < 200; c++) begin
            if (c % 2 == 0) begin
                gen(b);
                send(b, 1, 0);
                nv++;
                if (nv == 47) check("toggle_unlocked_47", locked, 0);
                if (nv == 48) check("toggle_locked_48", locked, 1);
            end else begin
                send(1'($urandom), 0, 0);
                check("idle_no_pulse", err_pulse, 0);
            end
        end
        // err_clr coinciding with an error
        do_reset(32'hFF);
        run_bits(60, 0);
        for (int e = 0; e < 5; e++) begin
            run_bits(9, 0);
            run_bits(1, 1);
        end
        check("count_5", err_count, 5);
        gen(b);
        send(!b, 1, 1);
        check("clr_with_err", err_count, 1);
        run_bits(3, 0);
        send(0, 1, 1);
        check("clr_only", err_count, 0);
        // Saturation of a 4-bit counter
        do_reset(32'hFF);
        run_bits(60, 0);
        for (int e = 0; e < 20; e++) begin
            run_bits(9, 0);
            run_bits(1, 1);
        end
        check("sat_count4", err_count4, 15);
        check("count_20", err_count, 20);
        do_reset(32'hFF);
        check("rst_locked", locked, 0);
        check("rst_state", state, 0);
        check("rst_count", err_count, 0);
        check("rst_pulse", err_pulse, 0);
        // Randomised streams with gaps, sporadic errors, bursts and clears
        for (int r = 0; r < 4; r++) begin
            do_reset($urandom | 32'h1);
            burst = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 3) == 0) send(1'($urandom), 0, $urandom_range(0, 49) == 0);
                else begin
                    gen(b);
                    if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(4, 12);
                    send(b ^ ($urandom_range(0, 99) < 2) ^ (burst > 0), 1, $urandom_range(0, 49) == 0);
                    if (burst > 0) burst--;
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
